imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle immediate extender.
- Takes the full 32-bit instruction word plus a one-hot format select. Extracts the immediate itself and sign-/zero-extends it to XLEN.
- Results are buffered in a 2-entry skid FIFO with valid/ready handshakes and a side-band tag.
- Sits between decode and the execute-stage operand mux. J-type is sign-extended, correcting the zero-extension of the previous generation.

Parameters:
- XLEN, 32, output datapath width; legal values 32 or 64.
- TAG_W, 5, width of the opaque tag carried alongside each immediate (e.g. rd or ROB index).

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  block can accept this cycle.
- instr  input  32  raw instruction word.
- ext_op  input  6  one-hot format select: bit0 I, bit1 S, bit2 B, bit3 U, bit4 J, bit5 SHAMT.
- in_tag  input  TAG_W  side-band tag.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream consumes head.
- immout  output  XLEN  extended immediate of head entry.
- out_tag  output  TAG_W  tag of head entry.
- out_err  output  1  head entry had illegal ext_op (zero or multi-hot).

Behaviour:
- Storage: 2-entry FIFO (rd/wr pointer, 2-bit count). Immediate is computed combinationally at input and stored with tag and err bit.
- Reset (rstn low, async): count=0, pointers=0, out_valid=0, in_ready=1, immout=0, out_tag=0, out_err=0.
- Handshake:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (count != 2), driven from the registered count only, with no combinational path from out_ready.
  - out_valid = (count != 0).
- Latency: an instruction pushed at edge N is visible on immout/out_valid in the cycle after edge N. Back-to-back throughput is 1 per cycle when out_ready stays high.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push & pop: unchanged; count=1 stays 1, count=0 cannot pop.
  - count=2: push impossible.
- immout/out_tag/out_err show the head entry whenever out_valid=1. When out_valid=0 they show 0.
- Hold rule: when out_valid & ~out_ready, head outputs remain stable until popped.
- flush:
  - Next edge sets count=0 and pointers=0.
  - A simultaneous push is dropped; flush has priority.
  - in_ready is unaffected in the flush cycle.
- Extraction, with S = instr[31] replicated to XLEN:
  - I: S-ext of instr[31:20].
  - S: S-ext of {instr[31:25], instr[11:7]}.
  - B: S-ext of {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: S-ext of {instr[31:12], 12'b0}; identity at XLEN=32.
  - J: S-ext of {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - SHAMT: zero-ext of instr[25:20] when XLEN=64, instr[24:20] when XLEN=32.
- Illegal ext_op (0 or more than one bit set): stored immediate=0, err=1. The entry is still pushed and popped normally.
- Reset asserted mid-transfer: all entries are lost immediately, and outputs go to reset values asynchronously.

Test Plan:
- XLEN=32, I-type instr=0xFFF00093 (addi x1,x0,-1), ext_op=000001 -> one cycle later out_valid=1, immout=0xFFFFFFFF.
- J-type instr=0x800000EF, ext_op=010000 -> immout=0xFFF00000 (sign-extended, not zero-extended). XLEN=64, U-type instr=0x800002B7 -> immout=0xFFFFFFFF80000000.
- Backpressure: out_ready=0, push three instrs with tags 1,2,3 -> in_ready drops after 2 accepted, tag 3 is held upstream. Raise out_ready -> tags emerge in order 1,2,3, one per cycle, with no loss or duplication.
- Simultaneous push/pop at count=1 with 100 random instr/ext_op pairs -> count stays 1; every immout matches the golden model; out_valid never drops.
- flush with count=2 and in_valid=1 on the same edge -> next cycle out_valid=0, in_ready=1, and the concurrently presented instr is not output.
- ext_op=000011 -> out_err=1, immout=0. Then assert rstn low mid-stream -> out_valid=0 and immout=0 without waiting for a clock edge.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe_if
// Description : Upstream/downstream handshake bundle for imm_gen_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [5:0]        ext_op;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   immout;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  modport master (
    output flush, in_valid, instr, ext_op, in_tag, out_ready,
    input  in_ready, out_valid, immout, out_tag, out_err
  );

  modport slave (
    input  flush, in_valid, instr, ext_op, in_tag, out_ready,
    output in_ready, out_valid, immout, out_tag, out_err
  );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : RISC-V immediate extractor/extender feeding a 2-entry FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  wire logic       clk,
  input  wire logic       rstn,
  imm_gen_pipe_if.slave   bus
);

  localparam logic [1:0] C_FULL = 2'd2;

  logic [XLEN-1:0]  w_imm;
  logic [XLEN-1:0]  w_imm_u;
  logic [XLEN-1:0]  w_shamt;
  logic             w_legal;
  logic             w_push;
  logic             w_pop;

  logic [1:0]       r_count;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [XLEN-1:0]  r_imm [2];
  logic [TAG_W-1:0] r_tag [2];
  logic             r_err [2];

  // U-type and SHAMT are the only formats whose layout depends on XLEN
  generate
    if (XLEN == 64) begin : g_xlen64
      assign w_imm_u = {{(XLEN-32){bus.instr[31]}}, bus.instr[31:12], 12'b0};
      assign w_shamt = {{(XLEN-6){1'b0}}, bus.instr[25:20]};
    end else begin : g_xlen32
      assign w_imm_u = {bus.instr[31:12], 12'b0};
      assign w_shamt = {{(XLEN-5){1'b0}}, bus.instr[24:20]};
    end
  endgenerate

  assign w_legal = (bus.ext_op != 6'd0) && ((bus.ext_op & (bus.ext_op - 6'd1)) == 6'd0);

  always_comb begin
    w_imm = '0;
    case (bus.ext_op)
      6'b000001: w_imm = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
      6'b000010: w_imm = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
      6'b000100: w_imm = {{(XLEN-13){bus.instr[31]}}, bus.instr[31], bus.instr[7],
                          bus.instr[30:25], bus.instr[11:8], 1'b0};
      6'b001000: w_imm = w_imm_u;
      6'b010000: w_imm = {{(XLEN-21){bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                          bus.instr[20], bus.instr[30:21], 1'b0};
      6'b100000: w_imm = w_shamt;
      default:   w_imm = '0;
    endcase
  end

  // flush wins over a concurrent push, so the dropped instruction never lands
  assign w_push = bus.in_valid & bus.in_ready & ~bus.flush;
  assign w_pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else if (bus.flush) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: the outputs are masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_imm[r_wr_ptr] <= w_imm;
      r_tag[r_wr_ptr] <= bus.in_tag;
      r_err[r_wr_ptr] <= ~w_legal;
    end
  end

  assign bus.in_ready  = (r_count != C_FULL);
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.immout    = bus.out_valid ? r_imm[r_rd_ptr] : '0;
  assign bus.out_tag   = bus.out_valid ? r_tag[r_rd_ptr] : '0;
  assign bus.out_err   = bus.out_valid ? r_err[r_rd_ptr] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Self-checking bench driving XLEN=32 and XLEN=64 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

  localparam int TAG_W = 5;

  typedef struct {
    logic [31:0]      instr;
    logic [5:0]       op;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;
  ent_t q[$];
  logic [TAG_W-1:0] popped[$];

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (.clk(clk), .rstn(rstn), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (.clk(clk), .rstn(rstn), .bus(b64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: immediate straight from the ISA field layouts
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [5:0] op, input int xl);
    longint v;
    v = 0;
    if ($countones(op) == 1) begin
      if (op[0]) v = longint'($signed(ins[31:20]));
      if (op[1]) v = longint'($signed({ins[31:25], ins[11:7]}));
      if (op[2]) v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      if (op[3]) v = longint'($signed({ins[31:12], 12'b0}));
      if (op[4]) v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      if (op[5]) v = (xl == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
    end
    if (xl == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  function automatic logic [5:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return 6'b000001 << (r % 6);
    return 6'($urandom);
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [5:0] op,
                       input logic [TAG_W-1:0] tg, input logic ordy, input logic fl);
    b32.in_valid = v;  b64.in_valid = v;
    b32.instr = ins;   b64.instr = ins;
    b32.ext_op = op;   b64.ext_op = op;
    b32.in_tag = tg;   b64.in_tag = tg;
    b32.out_ready = ordy; b64.out_ready = ordy;
    b32.flush = fl;    b64.flush = fl;
  endtask

  task automatic check_outputs();
    logic [63:0] e32, e64;
    logic e_err;
    logic [TAG_W-1:0] e_tag;
    e32 = '0; e64 = '0; e_err = 1'b0; e_tag = '0;
    if (q.size() != 0) begin
      e32   = ref_imm(q[0].instr, q[0].op, 32);
      e64   = ref_imm(q[0].instr, q[0].op, 64);
      e_err = ($countones(q[0].op) != 1);
      e_tag = q[0].tag;
    end
    chk("out_valid32", 64'(b32.out_valid), 64'(q.size() != 0));
    chk("out_valid64", 64'(b64.out_valid), 64'(q.size() != 0));
    chk("in_ready32",  64'(b32.in_ready),  64'(q.size() != 2));
    chk("in_ready64",  64'(b64.in_ready),  64'(q.size() != 2));
    chk("immout32",    64'(b32.immout),    e32);
    chk("immout64",    b64.immout,         e64);
    chk("out_tag32",   64'(b32.out_tag),   64'(e_tag));
    chk("out_tag64",   64'(b64.out_tag),   64'(e_tag));
    chk("out_err32",   64'(b32.out_err),   64'(e_err));
    chk("out_err64",   64'(b64.out_err),   64'(e_err));
  endtask

  task automatic step();
    bit   do_push, do_pop;
    ent_t e;
    check_outputs();
    do_push = b32.in_valid && (q.size() < 2) && !b32.flush;
    do_pop  = (q.size() > 0) && b32.out_ready && !b32.flush;
    e.instr = b32.instr; e.op = b32.ext_op; e.tag = b32.in_tag;
    if (do_pop) popped.push_back(b32.out_tag);
    @(posedge clk); #1;
    if (rstn) begin
      if (b32.flush) q.delete();
      else begin
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(e);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    drive(1'b0, 32'h0, 6'h0, '0, 1'b0, 1'b0);
    #1;
    check_outputs();
    step();
    rstn = 1'b1;
    step();

    // Directed formats with known constants
    drive(1'b1, 32'hFFF0_0093, 6'b000001, 5'd7, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 6'h0, '0, 1'b0, 1'b0);
    chk("i_imm32_const", 64'(b32.immout), 64'hFFFF_FFFF);
    step();
    drive(1'b1, 32'h8000_00EF, 6'b010000, 5'd8, 1'b1, 1'b0); step();
    drive(1'b0, 32'h0, 6'h0, '0, 1'b0, 1'b0);
    chk("j_imm32_const", 64'(b32.immout), 64'hFFF0_0000);
    chk("j_imm64_const", b64.immout, 64'hFFFF_FFFF_FFF0_0000);
    drive(1'b1, 32'h8000_02B7, 6'b001000, 5'd9, 1'b1, 1'b0); step();
    drive(1'b0, 32'h0, 6'h0, '0, 1'b0, 1'b0);
    chk("u_imm64_const", b64.immout, 64'hFFFF_FFFF_8000_0000);
    chk("u_imm32_const", 64'(b32.immout), 64'h8000_0000);
    drive(1'b0, 32'h0, 6'h0, '0, 1'b1, 1'b0); step(); step();

    // Backpressure: third entry must wait upstream
    popped.delete();
    drive(1'b1, 32'h0010_0093, 6'b000001, 5'd1, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0020_0093, 6'b000001, 5'd2, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0030_0093, 6'b000001, 5'd3, 1'b0, 1'b0); step();
    chk("bp_in_ready_full", 64'(b32.in_ready), 64'd0);
    step();
    drive(1'b1, 32'h0030_0093, 6'b000001, 5'd3, 1'b1, 1'b0); step(); step();
    drive(1'b0, 32'h0, 6'h0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("bp_pop_count", 64'(popped.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk("bp_tag_order", 64'(popped[i]), 64'(i + 1));

    // Simultaneous push/pop at occupancy one
    drive(1'b1, $urandom, rand_op(), 5'($urandom), 1'b0, 1'b0); step();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, $urandom, rand_op(), 5'($urandom), 1'b1, 1'b0);
      step();
      chk("pp_out_valid", 64'(b32.out_valid), 64'd1);
    end
    drive(1'b0, 32'h0, 6'h0, '0, 1'b1, 1'b0); step(); step();

    // Flush at full occupancy with a concurrent push
    drive(1'b1, 32'h1234_5093, 6'b000001, 5'd4, 1'b0, 1'b0); step();
    drive(1'b1, 32'h5432_1093, 6'b000010, 5'd5, 1'b0, 1'b0); step();
    drive(1'b1, 32'hDEAD_BEEF, 6'b000001, 5'd31, 1'b0, 1'b1);
    chk("fl_in_ready_during", 64'(b32.in_ready), 64'd0);
    step();
    drive(1'b0, 32'h0, 6'h0, '0, 1'b1, 1'b0);
    chk("fl_out_valid", 64'(b32.out_valid), 64'd0);
    chk("fl_in_ready", 64'(b32.in_ready), 64'd1);
    popped.delete();
    for (int i = 0; i < 3; i++) step();
    chk("fl_nothing_out", 64'(popped.size()), 64'd0);

    // Illegal ext_op, then asynchronous reset mid-stream
    drive(1'b1, 32'hFFF0_0093, 6'b000011, 5'd9, 1'b0, 1'b0); step();
    drive(1'b1, 32'h8000_00EF, 6'b010000, 5'd10, 1'b0, 1'b0);
    chk("ill_err", 64'(b32.out_err), 64'd1);
    chk("ill_imm", 64'(b32.immout), 64'd0);
    step();
    drive(1'b0, 32'h0, 6'h0, '0, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("arst_out_valid32", 64'(b32.out_valid), 64'd0);
    chk("arst_out_valid64", 64'(b64.out_valid), 64'd0);
    chk("arst_immout32", 64'(b32.immout), 64'd0);
    chk("arst_immout64", b64.immout, 64'd0);
    chk("arst_in_ready", 64'(b32.in_ready), 64'd1);
    q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    check_outputs();

    // Random traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, rand_op(), 5'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      step();
    end
    drive(1'b0, 32'h0, 6'h0, '0, 1'b1, 1'b0);
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
